vga_timing_gen: RTL

- Upstream neighbour of the character/pixel video generator.
- Derives the pixel-rate enable from the system clock and runs horizontal and vertical counters.
- Drives the pixel coordinates x/y consumed by the video generator, plus hsync, vsync, blank_n, pixel clock and frame/line markers for the VGA DAC and connector.
- Default timing is 640x480@60 Hz from a 50 MHz clk.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_timing_gen_pixel_tick_div.sv | 42 ++++
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and small helpers for the VGA
// timing generator. Default timing assumes a 50 MHz clk and CLK_DIV = 2.
package vga_pkg;

   typedef logic [9:0] coord_t;

   // Default timing, in pixels (horizontal) and lines (vertical)
   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_SYNC_POL = 0;

   // Derived default totals and sync windows (start inclusive, end exclusive)
   localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
   localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

   // Map "sync window active" onto the physical pin level for a polarity
   function automatic logic sync_level(input logic active, input logic pol);
      return active ? pol : ~pol;
   endfunction

   // Half-open window test on a coordinate: lo <= c < hi
   function automatic logic in_window(input coord_t c, input int lo, input int hi);
      return (int'(c) >= lo) && (int'(c) < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel clock, coordinates, syncs, blanking and
// line/frame markers. The timing generator drives it (master), the video
// generator and DAC/connector logic consume it (slave).
interface vga_timing_gen_if;
   import vga_pkg::*;

   logic   vgaclk;
   coord_t x;
   coord_t y;
   logic   hsync;
   logic   vsync;
   logic   blank_n;
   logic   line_start;
   logic   frame_start;

   modport master (
      output vgaclk, x, y, hsync, vsync, blank_n, line_start, frame_start
   );

   modport slave (
      input  vgaclk, x, y, hsync, vsync, blank_n, line_start, frame_start
   );

endinterface

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Pixel-rate divider: counts clk cycles 0..CLK_DIV-1 and flags the last one
// as the pixel tick. Also produces the registered pixel clock for the DAC,
// low for the first half of each pixel and high for the second half.
// CLK_DIV legal range is 2..16.
module pixel_tick_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o,
   output logic vgaclk_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

   logic [CW-1:0] div_cnt_q;
   logic [CW-1:0] div_cnt_d;
   logic          vgaclk_q;

   // Next divider count, wrapping after the last cycle of a pixel
   always_comb begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
   end

   // Divider count and pixel clock; the clock is decoded from the next count
   // so it falls on the same edge the pixel counters advance
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         vgaclk_q  <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         vgaclk_q  <= (div_cnt_d >= HALF);
      end
   end

   assign tick_o   = (div_cnt_q == LAST);
   assign vgaclk_o = vgaclk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal/vertical counters advanced at pixel rate,
// with sync, blanking and line/frame markers registered from the next-state
// counters so coordinates and syncs change on the same clk edge.
// Optional build macro VGA_PIPE_DELAY_EN: delays hsync, vsync and blank_n by
// one pixel period to line up with a one-pixel-latency glyph ROM downstream.
// Constraint: each of H and V totals must not exceed 1024.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int SYNC_POL = DEF_SYNC_POL
) (
   input  logic                clk,
   input  logic                rst_n,
   vga_timing_gen_if.master    vga
);

   localparam int     TOT_H    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int     TOT_V    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int     HS_START = H_ACTIVE + H_FP;
   localparam int     HS_END   = HS_START + H_SYNC;
   localparam int     VS_START = V_ACTIVE + V_FP;
   localparam int     VS_END   = VS_START + V_SYNC;
   localparam coord_t X_LAST   = coord_t'(TOT_H - 1);
   localparam coord_t Y_LAST   = coord_t'(TOT_V - 1);
   localparam logic   POL      = (SYNC_POL != 0);

   logic   tick;
   logic   x_wrap;
   logic   y_wrap;

   coord_t x_q, x_d;
   coord_t y_q, y_d;
   logic   hsync_q, hsync_d;
   logic   vsync_q, vsync_d;
   logic   blank_n_q, blank_n_d;
   logic   line_start_q, line_start_d;
   logic   frame_start_q, frame_start_d;

   pixel_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_o   (tick),
      .vgaclk_o (vga.vgaclk)
   );

   // Next-state counters and the decode of those next-state values
   always_comb begin
      x_wrap = tick && (x_q == X_LAST);
      y_wrap = x_wrap && (y_q == Y_LAST);

      x_d = x_q;
      y_d = y_q;
      if (tick) begin
         x_d = x_wrap ? '0 : x_q + coord_t'(1);
      end
      if (x_wrap) begin
         y_d = y_wrap ? '0 : y_q + coord_t'(1);
      end

      hsync_d       = sync_level(in_window(x_d, HS_START, HS_END), POL);
      vsync_d       = sync_level(in_window(y_d, VS_START, VS_END), POL);
      blank_n_d     = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
      line_start_d  = x_wrap;
      frame_start_d = y_wrap;
   end

   // Counter and decoded-output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q           <= '0;
         y_q           <= '0;
         hsync_q       <= ~POL;
         vsync_q       <= ~POL;
         blank_n_q     <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_n_q     <= blank_n_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

`ifdef VGA_PIPE_DELAY_EN
   logic hsync_dly_q;
   logic vsync_dly_q;
   logic blank_n_dly_q;

   // One-pixel delay of syncs and blanking, stepped on the pixel tick so the
   // stage captures the value held during the pixel that is just ending
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsync_dly_q   <= ~POL;
         vsync_dly_q   <= ~POL;
         blank_n_dly_q <= 1'b0;
      end else if (tick) begin
         hsync_dly_q   <= hsync_q;
         vsync_dly_q   <= vsync_q;
         blank_n_dly_q <= blank_n_q;
      end
   end

   assign vga.hsync   = hsync_dly_q;
   assign vga.vsync   = vsync_dly_q;
   assign vga.blank_n = blank_n_dly_q;
`else
   assign vga.hsync   = hsync_q;
   assign vga.vsync   = vsync_q;
   assign vga.blank_n = blank_n_q;
`endif

endmodule
